// File: rtl/uart_pkg.sv
// Shared constants, FSM encodings and the parity helper used by the UART datapath.
package uart_pkg;
   localparam int PARITY_NONE = 0;
   localparam int PARITY_ODD  = 1;
   localparam int PARITY_EVEN = 2;

   // Bit positions inside the 2-bit rx_err field
   localparam int ERR_FRAME  = 0;
   localparam int ERR_PARITY = 1;

   typedef enum logic [2:0] {
      TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
   } tx_state_e;

   typedef enum logic [2:0] {
      RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
   } rx_state_e;

   // Zero-extended data keeps its parity, so one 8-bit helper covers 5..8 data bits
   function automatic logic par_bit(input logic [7:0] d, input int kind);
      return (kind == PARITY_ODD) ? ~(^d) : (^d);
   endfunction
endpackage

// File: rtl/uart_fifo_sync_fifo.sv
// First-word-fall-through synchronous FIFO; head is visible on o_rdata while not empty.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty,
   output logic [AW:0]      o_level
);
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wptr;
   logic [AW:0]      r_rptr;
   logic             w_push;
   logic             w_pop;

   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;
   assign o_level = r_wptr - r_rptr;
   assign o_full  = (o_level == (AW+1)'(DEPTH));
   assign o_empty = (o_level == '0);
   assign o_rdata = r_mem[r_rptr[AW-1:0]];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
   end
endmodule

// File: rtl/uart_fifo.sv
// Full-duplex UART with runtime baud divisor, configurable frame format and TX/RX FWFT FIFOs.
module uart_fifo
   import uart_pkg::*;
#(
   parameter int CLK_DIV    = 105,
   parameter int DIV_W      = 16,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16,
   localparam int LW        = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_div_we,
   input  logic [DIV_W-1:0]     i_div_wdata,
   output logic                 o_tx,
   input  logic                 i_tx_valid,
   input  logic [DATA_BITS-1:0] i_tx_data,
   output logic                 o_tx_ready,
   output logic                 o_tx_idle,
   input  logic                 i_rx,
   output logic                 o_rx_valid,
   output logic [DATA_BITS-1:0] o_rx_data,
   output logic [1:0]           o_rx_err,
   input  logic                 i_rx_ready,
   output logic                 o_rx_overrun,
   input  logic                 i_ovr_clr,
   output logic [LW-1:0]        o_tx_level,
   output logic [LW-1:0]        o_rx_level
);
   localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);
   localparam logic [DIV_W-1:0] DIV_RST  = DIV_W'(CLK_DIV);
   localparam bit               HAS_PAR  = (PARITY != PARITY_NONE);

   logic [DIV_W-1:0] r_div;

   always_ff @(posedge i_clk) begin
      if (i_rst)                                   r_div <= DIV_RST;
      else if (i_div_we && i_div_wdata >= DIV_W'(4)) r_div <= i_div_wdata;
   end

   // ---------------- TX ----------------
   logic [DATA_BITS-1:0] w_txf_rdata;
   logic                 w_txf_full;
   logic                 w_txf_empty;
   logic                 w_tx_pop;
   logic                 w_tx_tick;
   logic                 w_tx_stop_last;
   tx_state_e            r_tx_st;
   logic                 r_tx;
   logic [DIV_W-1:0]     r_tx_cnt;
   logic [DIV_W-1:0]     r_tx_div;
   logic [2:0]           r_tx_bit;
   logic                 r_tx_stop;
   logic [DATA_BITS-1:0] r_tx_sh;
   logic                 r_tx_par;

   sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_txf (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (i_tx_valid),
      .i_wdata (i_tx_data),
      .i_pop   (w_tx_pop),
      .o_rdata (w_txf_rdata),
      .o_full  (w_txf_full),
      .o_empty (w_txf_empty),
      .o_level (o_tx_level)
   );

   assign w_tx_tick      = (r_tx_cnt == r_tx_div - DIV_W'(1));
   assign w_tx_stop_last = (STOP_BITS == 1) || r_tx_stop;
   // Reloading straight from the end of STOP keeps back-to-back frames gapless
   assign w_tx_pop       = ~w_txf_empty &&
                           ((r_tx_st == TX_IDLE) ||
                            (r_tx_st == TX_STOP && w_tx_tick && w_tx_stop_last));
   assign o_tx           = r_tx;
   assign o_tx_ready     = ~w_txf_full;
   assign o_tx_idle      = w_txf_empty && (r_tx_st == TX_IDLE);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_tx_st   <= TX_IDLE;
         r_tx      <= 1'b1;
         r_tx_cnt  <= '0;
         r_tx_div  <= DIV_RST;
         r_tx_bit  <= '0;
         r_tx_stop <= 1'b0;
         r_tx_sh   <= '0;
         r_tx_par  <= 1'b0;
      end else if (w_tx_pop) begin
         r_tx_st  <= TX_START;
         r_tx     <= 1'b0;
         r_tx_cnt <= '0;
         r_tx_div <= r_div;
         r_tx_sh  <= w_txf_rdata;
         r_tx_par <= par_bit(8'(w_txf_rdata), PARITY);
      end else begin
         r_tx_cnt <= w_tx_tick ? '0 : r_tx_cnt + DIV_W'(1);
         case (r_tx_st)
            TX_START: if (w_tx_tick) begin
               r_tx_st  <= TX_DATA;
               r_tx_bit <= '0;
               r_tx     <= r_tx_sh[0];
            end
            TX_DATA: if (w_tx_tick) begin
               if (r_tx_bit == LAST_BIT) begin
                  r_tx_st   <= HAS_PAR ? TX_PARITY : TX_STOP;
                  r_tx      <= HAS_PAR ? r_tx_par : 1'b1;
                  r_tx_stop <= 1'b0;
               end else begin
                  r_tx_bit <= r_tx_bit + 3'd1;
                  r_tx_sh  <= r_tx_sh >> 1;
                  r_tx     <= r_tx_sh[1];
               end
            end
            TX_PARITY: if (w_tx_tick) begin
               r_tx_st   <= TX_STOP;
               r_tx      <= 1'b1;
               r_tx_stop <= 1'b0;
            end
            TX_STOP: if (w_tx_tick) begin
               if (w_tx_stop_last) r_tx_st <= TX_IDLE;
               else                r_tx_stop <= 1'b1;
            end
            default: begin
               r_tx_st  <= TX_IDLE;
               r_tx     <= 1'b1;
               r_tx_cnt <= '0;
            end
         endcase
      end
   end

   // ---------------- RX ----------------
   logic                   r_rx_s1;
   logic                   r_rx_s2;
   logic                   w_rxs;
   rx_state_e              r_rx_st;
   logic [DIV_W-1:0]       r_rx_cnt;
   logic [DIV_W-1:0]       r_rx_div;
   logic [2:0]             r_rx_bit;
   logic [DATA_BITS-1:0]   r_rx_sh;
   logic                   r_rx_perr;
   logic                   r_rx_brk;
   logic                   r_ovr;
   logic                   w_rx_tick;
   logic                   w_rx_half;
   logic                   w_rx_push;
   logic [DATA_BITS+1:0]   w_rx_wdata;
   logic [DATA_BITS+1:0]   w_rxf_rdata;
   logic                   w_rxf_full;
   logic                   w_rxf_empty;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rx_s1 <= 1'b1;
         r_rx_s2 <= 1'b1;
      end else begin
         r_rx_s1 <= i_rx;
         r_rx_s2 <= r_rx_s1;
      end
   end

   assign w_rxs      = r_rx_s2;
   assign w_rx_tick  = (r_rx_cnt == r_rx_div - DIV_W'(1));
   assign w_rx_half  = (r_rx_cnt == (r_rx_div >> 1) - DIV_W'(1));
   assign w_rx_push  = (r_rx_st == RX_STOP) && !r_rx_brk && w_rx_tick;
   assign w_rx_wdata = {r_rx_perr, ~w_rxs, r_rx_sh};

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rx_st   <= RX_IDLE;
         r_rx_cnt  <= '0;
         r_rx_div  <= DIV_RST;
         r_rx_bit  <= '0;
         r_rx_sh   <= '0;
         r_rx_perr <= 1'b0;
         r_rx_brk  <= 1'b0;
      end else begin
         case (r_rx_st)
            RX_IDLE: if (!w_rxs) begin
               r_rx_st   <= RX_START;
               r_rx_cnt  <= '0;
               r_rx_div  <= r_div;
               r_rx_perr <= 1'b0;
            end
            RX_START: begin
               r_rx_cnt <= w_rx_half ? '0 : r_rx_cnt + DIV_W'(1);
               if (w_rx_half) begin
                  r_rx_st  <= w_rxs ? RX_IDLE : RX_DATA;
                  r_rx_bit <= '0;
               end
            end
            RX_DATA: begin
               r_rx_cnt <= w_rx_tick ? '0 : r_rx_cnt + DIV_W'(1);
               if (w_rx_tick) begin
                  r_rx_sh  <= {w_rxs, r_rx_sh[DATA_BITS-1:1]};
                  r_rx_bit <= r_rx_bit + 3'd1;
                  if (r_rx_bit == LAST_BIT) r_rx_st <= HAS_PAR ? RX_PARITY : RX_STOP;
               end
            end
            RX_PARITY: begin
               r_rx_cnt <= w_rx_tick ? '0 : r_rx_cnt + DIV_W'(1);
               if (w_rx_tick) begin
                  r_rx_perr <= (w_rxs != par_bit(8'(r_rx_sh), PARITY));
                  r_rx_st   <= RX_STOP;
               end
            end
            RX_STOP: begin
               // A low stop bit parks here until the line is released, so a break is one character
               if (r_rx_brk) begin
                  if (w_rxs) begin
                     r_rx_brk <= 1'b0;
                     r_rx_st  <= RX_IDLE;
                  end
               end else begin
                  r_rx_cnt <= w_rx_tick ? '0 : r_rx_cnt + DIV_W'(1);
                  if (w_rx_tick) begin
                     if (w_rxs) r_rx_st  <= RX_IDLE;
                     else       r_rx_brk <= 1'b1;
                  end
               end
            end
            default: r_rx_st <= RX_IDLE;
         endcase
      end
   end

   sync_fifo #(.WIDTH(DATA_BITS + 2), .DEPTH(FIFO_DEPTH)) u_rxf (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (w_rx_push),
      .i_wdata (w_rx_wdata),
      .i_pop   (i_rx_ready),
      .o_rdata (w_rxf_rdata),
      .o_full  (w_rxf_full),
      .o_empty (w_rxf_empty),
      .o_level (o_rx_level)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) r_ovr <= 1'b0;
      else       r_ovr <= (r_ovr & ~i_ovr_clr) | (w_rx_push & w_rxf_full);
   end

   assign o_rx_valid   = ~w_rxf_empty;
   assign o_rx_data    = w_rxf_rdata[DATA_BITS-1:0];
   assign o_rx_err     = {w_rxf_rdata[DATA_BITS+ERR_PARITY], w_rxf_rdata[DATA_BITS+ERR_FRAME]};
   assign o_rx_overrun = r_ovr;
endmodule
